regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor of the CPU's 8x8 register bank: configurable data width and register count.
- Optional hard-wired zero register and optional write-to-read bypass.
- Adds a sequential clear engine that zeroes the file one register per cycle and reports busy.
- Sits in the datapath between decode/writeback and the ALU, and drives the flattened register view used by the board display/debug logic.

Parameters:
DATA_W, 8, data width of each register
ADDR_W, 3, register address width; NREG = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register
BYPASS, 1, 1 = accepted same-cycle write data is forwarded to read ports; 0 = reads show stored contents only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
we3  in  1  write enable
wa3  in  ADDR_W  write address
wd3  in  DATA_W  write data
ra1  in  ADDR_W  read address port 1
ra2  in  ADDR_W  read address port 2
rd1  out  DATA_W  read data port 1 (combinational)
rd2  out  DATA_W  read data port 2 (combinational)
clr_req  in  1  request full-file clear
busy  out  1  clear sequence in progress
regs_flat  out  DATA_W*NREG  all stored registers; reg i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (rst=1 at a rising edge):
  - All registers become 0; FSM goes to IDLE; clear counter becomes 0; busy=0.
  - rst overrides we3 and clr_req on the same edge.
- Storage:
  - NREG x DATA_W flops.
  - With ZERO_REG=1, register 0 is never written: it is constant 0 in storage, in regs_flat and on the read ports.
- Write acceptance:
  - A write is accepted when we3=1, state=IDLE and rst=0; reg[wa3] takes wd3 at that edge.
  - Writes to register 0 are discarded when ZERO_REG=1.
  - Writes presented while busy=1 are dropped silently. No queueing, no error flag.
- Reads:
  - Purely combinational: rdN = reg[raN].
  - Forced to 0 when raN=0 and ZERO_REG=1.
- Bypass (BYPASS=1):
  - If a write is being accepted this cycle and wa3==raN (excluding address 0 when ZERO_REG=1), rdN = wd3 in the same cycle.
  - Both ports bypass independently.
  - regs_flat is never bypassed.
- FSM states and transitions:
  - IDLE: busy=0. On clr_req=1 at an edge, go to CLEAR with cnt=0. A we3 on that same edge is still accepted, and is later overwritten by the clear.
  - CLEAR: busy=1. Each edge writes reg[cnt]=0 and increments cnt. At the edge where cnt==NREG-1, reg[NREG-1] is cleared, cnt returns to 0 and the FSM goes to IDLE.
  - clr_req is ignored while in CLEAR (no restart, no extension).
- Clear timing:
  - clr_req sampled at edge k gives busy=1 from after edge k until edge k+NREG.
  - Registers 0..NREG-1 are zeroed at edges k+1..k+NREG respectively.
  - busy=0 after edge k+NREG; a new clr_req is accepted at edge k+NREG or later.
- Reads during CLEAR return current contents: already-cleared registers show 0, the rest keep their old values.
- Reset mid-clear aborts immediately: all registers 0, IDLE, cnt=0 after that edge.
- Widths: cnt is ADDR_W bits and wraps naturally at NREG-1→0. No arithmetic on data.

Test Plan:
- Reset then write, defaults: rst 1 cycle, then write 8'hA5 to r3, 8'h3C to r7, ra1=3, ra2=7 → after write edges rd1=A5, rd2=3C; regs_flat[63:56]=3C, [31:24]=A5, all other bytes 00.
- Zero register: we3=1, wa3=0, wd3=FF, ra1=0 → rd1=00 during and after the edge; regs_flat[7:0]=00. Rebuild with ZERO_REG=0 and repeat → rd1=FF after the edge.
- Bypass: r5=11, then we3=1, wa3=5, wd3=22, ra1=ra2=5 in the same cycle → rd1=rd2=22 before the edge (BYPASS=1). With BYPASS=0 → 11 before the edge, 22 after.
- Clear sequence: fill r1..r7 with 01..07, pulse clr_req at edge k → busy high for exactly 8 cycles. At edge k+4 (r3 cleared), ra1=4 reads 04 and ra1=3 reads 00. After k+8 all regs are 00 and busy=0.
- Writes while busy: during CLEAR drive we3=1, wa3=6, wd3=99 at edge k+2 → dropped, r6=00 at the end. A re-pulse of clr_req at k+3 → busy still falls after k+8.
- Reset mid-clear: clr_req at k, rst at k+3 → after k+3 busy=0, all regs 00. The next write of 5A to r2 at k+4 is accepted and rd on r2 shows 5A.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file with optional zero register, optional write-to-read
// bypass and a sequential clear engine that zeroes one register per cycle.
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we3,
  input  logic [ADDR_W-1:0]             wa3,
  input  logic [DATA_W-1:0]             wd3,
  input  logic [ADDR_W-1:0]             ra1,
  input  logic [ADDR_W-1:0]             ra2,
  output logic [DATA_W-1:0]             rd1,
  output logic [DATA_W-1:0]             rd2,
  input  logic                          clr_req,
  output logic                          busy,
  output logic [DATA_W*(2**ADDR_W)-1:0] regs_flat
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  // Handshake: there is none. A write is accepted whenever we3=1 in IDLE with
  // rst=0; anything presented while busy is dropped without notice.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clear_en;
  logic              wr_acc;
  logic              zero_wa;

  assign clear_en = (state_q == CLEAR);
  assign busy     = clear_en;
  assign zero_wa  = (ZERO_REG != 0) && (wa3 == '0);
  assign wr_acc   = we3 && !rst && (state_q == IDLE) && !zero_wa;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // clr_req is deliberately not looked at here: no restart, no extension.
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [DATA_W-1:0] q;
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign q = '0;
    end else begin : g_flop
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (clear_en && (cnt_q == ADDR_W'(g))) begin
          q <= '0;
        end else if (wr_acc && (wa3 == ADDR_W'(g))) begin
          q <= wd3;
        end
      end
    end
    assign regs_flat[g*DATA_W +: DATA_W] = q;
  end

  // Bypass forwards only writes that will actually land, so address 0 under
  // ZERO_REG and writes dropped during a clear are never forwarded.
  always_comb begin
    rd1 = regs_flat[ra1*DATA_W +: DATA_W];
    if ((BYPASS != 0) && wr_acc && (wa3 == ra1)) rd1 = wd3;
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = regs_flat[ra2*DATA_W +: DATA_W];
    if ((BYPASS != 0) && wr_acc && (wa3 == ra2)) rd2 = wd3;
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default build plus a ZERO_REG=0/BYPASS=0 build on the
// same stimulus, both checked against an array-based model of the file.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we3 = 1'b0;
  logic [2:0]  wa3 = '0;
  logic [7:0]  wd3 = '0;
  logic [2:0]  ra1 = '0;
  logic [2:0]  ra2 = '0;
  logic        clr_req = 1'b0;
  logic [7:0]  rd1, rd2, rd1_b, rd2_b;
  logic        busy, busy_b;
  logic [63:0] regs_flat, flat_b;

  int checks = 0;
  int failures = 0;

  // Model state: m_a for the default build, m_b for the plain build.
  logic [7:0] m_a [8];
  logic [7:0] m_b [8];
  logic       busy_m = 1'b0;
  int         pos_m = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .clr_req(clr_req), .busy(busy), .regs_flat(regs_flat)
  );

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .clr_req(clr_req), .busy(busy_b), .regs_flat(flat_b)
  );

  // Advance one rising edge, apply the rules to the model, settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_a[i] = '0;
        m_b[i] = '0;
      end
      busy_m = 1'b0;
      pos_m  = 0;
    end else if (busy_m) begin
      m_a[pos_m] = '0;
      m_b[pos_m] = '0;
      pos_m++;
      if (pos_m == 8) begin
        busy_m = 1'b0;
        pos_m  = 0;
      end
    end else begin
      if (we3) begin
        if (wa3 != 3'd0) m_a[wa3] = wd3;
        m_b[wa3] = wd3;
      end
      if (clr_req) begin
        busy_m = 1'b1;
        pos_m  = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a1, input logic [2:0] a2, input logic clr);
    we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2; clr_req = clr;
  endtask

  function automatic logic [7:0] exp_rd_a(input logic [2:0] ra);
    if (ra == 3'd0) return 8'h00;
    if (!rst && !busy_m && we3 && (wa3 == ra)) return wd3;
    return m_a[ra];
  endfunction

  function automatic logic [63:0] flat_a();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_a[i];
    return f;
  endfunction

  function automatic logic [63:0] flat_b_m();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_b[i];
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'($urandom_range(1, 7)), 8'($urandom), 3'd1, 3'd2, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b/%b want 0/0", busy, busy_b);
    end
    checks++;
    if (regs_flat !== 64'h0 || flat_b !== 64'h0) begin
      failures++;
      $display("FAIL reset_flat: got %h/%h want 0", regs_flat, flat_b);
    end
    checks++;
    if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_rd: got %h/%h want 00/00", rd1, rd2);
    end
  endtask

  task automatic test_write_basic();
    drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd7, 1'b0);
    tick();
    drive(1'b1, 3'd7, 8'h3C, 3'd3, 3'd7, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0);
    #1;
    checks++;
    if (rd1 !== 8'hA5 || rd2 !== 8'h3C) begin
      failures++;
      $display("FAIL write_rd: got %h/%h want a5/3c", rd1, rd2);
    end
    checks++;
    if (regs_flat !== 64'h3C00_0000_A500_0000) begin
      failures++;
      $display("FAIL write_flat: got %h want 3c000000a5000000", regs_flat);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0);
    #1;
    checks++;
    if (rd1 !== 8'h00 || rd1_b !== 8'h00) begin
      failures++;
      $display("FAIL zero_before: got %h/%h want 00/00", rd1, rd1_b);
    end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 8'h00 || regs_flat[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL zero_after: got rd %h flat %h want 00/00", rd1, regs_flat[7:0]);
    end
    checks++;
    if (rd1_b !== 8'hFF || flat_b[7:0] !== 8'hFF) begin
      failures++;
      $display("FAIL zero_plain: got rd %h flat %h want ff/ff", rd1_b, flat_b[7:0]);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 3'd5, 8'h11, 3'd5, 3'd5, 1'b0);
    tick();
    drive(1'b1, 3'd5, 8'h22, 3'd5, 3'd5, 1'b0);
    #1;
    checks++;
    if (rd1 !== 8'h22 || rd2 !== 8'h22) begin
      failures++;
      $display("FAIL bypass_fwd: got %h/%h want 22/22", rd1, rd2);
    end
    checks++;
    if (rd1_b !== 8'h11 || rd2_b !== 8'h11) begin
      failures++;
      $display("FAIL bypass_off: got %h/%h want 11/11", rd1_b, rd2_b);
    end
    checks++;
    if (regs_flat[47:40] !== 8'h11) begin
      failures++;
      $display("FAIL bypass_flat: got %h want 11", regs_flat[47:40]);
    end
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 8'h22 || rd1_b !== 8'h22) begin
      failures++;
      $display("FAIL bypass_after: got %h/%h want 22/22", rd1, rd1_b);
    end
  endtask

  task automatic test_clear_seq();
    int n;
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'(i), 3'd4, 3'd3, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 1'b1);
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      we3 = (n == 2);
      wa3 = 3'd6;
      wd3 = 8'h99;
      clr_req = (n == 3);
      #1;
      if (n == 2) begin
        checks++;
        if (rd1 !== 8'h04) begin
          failures++;
          $display("FAIL clear_no_bypass: got %h want 04", rd1);
        end
      end
      tick();
      if (n == 4) begin
        checks++;
        if (rd1 !== 8'h04 || rd2 !== 8'h00) begin
          failures++;
          $display("FAIL clear_partial: got r4 %h r3 %h want 04/00", rd1, rd2);
        end
      end
    end
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0);
    #1;
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL clear_len: got %0d busy cycles want 8", n);
    end
    checks++;
    if (busy !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL clear_done: got busy %b/%b want 0/0", busy, busy_b);
    end
    checks++;
    if (regs_flat !== 64'h0 || flat_b !== 64'h0) begin
      failures++;
      $display("FAIL clear_flat: got %h/%h want 0", regs_flat, flat_b);
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'($urandom_range(1, 255)), 3'd2, 3'd2, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b1);
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || regs_flat !== 64'h0 || flat_b !== 64'h0) begin
      failures++;
      $display("FAIL abort_clear: got busy %b flat %h/%h want 0/0/0", busy, regs_flat, flat_b);
    end
    drive(1'b1, 3'd2, 8'h5A, 3'd2, 3'd2, 1'b0);
    tick();
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 8'h5A || rd1_b !== 8'h5A) begin
      failures++;
      $display("FAIL abort_write: got %h/%h want 5a/5a", rd1, rd1_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      we3     = 1'($urandom);
      wa3     = 3'($urandom);
      wd3     = 8'($urandom);
      ra1     = 3'($urandom);
      ra2     = ($urandom_range(0, 3) == 0) ? wa3 : 3'($urandom);
      clr_req = ($urandom_range(0, 24) == 0);
      #1;
      checks++;
      if (rd1 !== exp_rd_a(ra1) || rd2 !== exp_rd_a(ra2)) begin
        failures++;
        $display("FAIL rand_rd i=%0d: got %h/%h want %h/%h", i, rd1, rd2, exp_rd_a(ra1), exp_rd_a(ra2));
      end
      checks++;
      if (rd1_b !== m_b[ra1] || rd2_b !== m_b[ra2]) begin
        failures++;
        $display("FAIL rand_rd_plain i=%0d: got %h/%h want %h/%h", i, rd1_b, rd2_b, m_b[ra1], m_b[ra2]);
      end
      checks++;
      if (busy !== busy_m || busy_b !== busy_m) begin
        failures++;
        $display("FAIL rand_busy i=%0d: got %b/%b want %b", i, busy, busy_b, busy_m);
      end
      checks++;
      if (regs_flat !== flat_a() || flat_b !== flat_b_m()) begin
        failures++;
        $display("FAIL rand_flat i=%0d: got %h/%h want %h/%h", i, regs_flat, flat_b, flat_a(), flat_b_m());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    test_reset();
    test_write_basic();
    test_zero_reg();
    test_bypass();
    test_clear_seq();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
